spmv_stream: RTL and testbench

//   Parametrised sparse matrix-vector multiply engine, y = W*x. Loads a dense vector x, then

---
 rtl/spmv_stream.sv | 170 +++++++++++++++++
 tb/tb_spmv_stream.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_stream.sv
// Sparse matrix-vector multiply engine: loads x, accumulates (row,col,data) triplets
// through a 2-stage MAC into per-row sums, then streams the row sums out under valid/ready.
module spmv_stream #(
    parameter int DIM       = 32,
    parameter int DW        = 8,
    parameter int SIGNED    = 0,
    parameter int SKIP_ZERO = 1,
    localparam int IW = $clog2(DIM),
    localparam int AW = 2*DW + $clog2(DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          in_ready_o,
    input  logic          vec_valid_i,
    input  logic [IW-1:0] vec_idx_i,
    input  logic [DW-1:0] vec_data_i,
    input  logic          w_valid_i,
    input  logic [IW-1:0] w_row_i,
    input  logic [IW-1:0] w_col_i,
    input  logic [DW-1:0] w_data_i,
    input  logic          w_last_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [IW-1:0] out_row_o,
    output logic [AW-1:0] out_data_o,
    output logic          out_last_o
);

    typedef enum logic [1:0] {LOAD, DRAIN, OUTPUT, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   x_q   [DIM];
    logic [AW-1:0]   acc_q [DIM];

    logic            s1Valid_q;
    logic [IW-1:0]   s1Row_q;
    logic [2*DW-1:0] s1Prod_q;

    logic [IW-1:0]   scan_q, scan_d;
    logic            outValid_q, outValid_d;
    logic [IW-1:0]   outRow_q, outRow_d;
    logic [AW-1:0]   outData_q, outData_d;
    logic            outLast_q, outLast_d;

    logic            loading;
    logic            vecHit, wAccept, wHit, wRowOk, wColOk;
    logic [IW-1:0]   colSafe;
    logic [DW-1:0]   xSel;
    logic [2*DW-1:0] wExt, xExt, prod;
    logic            pSign;
    logic [AW-1:0]   addend;
    logic            scanAtEnd, emitRow;

    assign loading    = (state_q == LOAD);
    assign in_ready_o = loading;

    assign vecHit  = loading && vec_valid_i && (32'(vec_idx_i) < DIM);
    assign wAccept = loading && w_valid_i;
    assign wRowOk  = (32'(w_row_i) < DIM);
    assign wColOk  = (32'(w_col_i) < DIM);
    assign wHit    = wAccept && wRowOk && wColOk;

    // Low 2*DW bits of the product of sign/zero-extended operands give the signed/unsigned product.
    assign colSafe = wColOk ? w_col_i : '0;
    assign xSel    = x_q[colSafe];
    assign wExt    = {{DW{(SIGNED != 0) & w_data_i[DW-1]}}, w_data_i};
    assign xExt    = {{DW{(SIGNED != 0) & xSel[DW-1]}}, xSel};
    assign prod    = wExt * xExt;

    assign pSign  = (SIGNED != 0) & s1Prod_q[2*DW-1];
    assign addend = {{(AW-2*DW){pSign}}, s1Prod_q};

    assign scanAtEnd = (scan_q == IW'(DIM-1));
    assign emitRow   = (SKIP_ZERO == 0) || (acc_q[scan_q] != '0) || scanAtEnd;

    always_comb begin
        state_d    = state_q;
        scan_d     = scan_q;
        outValid_d = outValid_q;
        outRow_d   = outRow_q;
        outData_d  = outData_q;
        outLast_d  = outLast_q;
        case (state_q)
            LOAD: begin
                if (wAccept && w_last_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!s1Valid_q) begin
                    state_d = OUTPUT;
                    scan_d  = '0;
                end
            end
            OUTPUT: begin
                if (outValid_q && out_ready_i && outLast_q) begin
                    state_d    = CLEAR;
                    outValid_d = 1'b0;
                end else if (!outValid_q || out_ready_i) begin
                    // One row examined per free slot; row DIM-1 always loads and then holds until accepted.
                    outValid_d = 1'b0;
                    if (emitRow) begin
                        outValid_d = 1'b1;
                        outRow_d   = scan_q;
                        outData_d  = acc_q[scan_q];
                        outLast_d  = scanAtEnd;
                    end
                    if (!scanAtEnd) scan_d = scan_q + 1'b1;
                end
            end
            CLEAR: begin
                state_d    = LOAD;
                outValid_d = 1'b0;
                outLast_d  = 1'b0;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            scan_q     <= '0;
            outValid_q <= 1'b0;
            outRow_q   <= '0;
            outData_q  <= '0;
            outLast_q  <= 1'b0;
            s1Valid_q  <= 1'b0;
            s1Row_q    <= '0;
            s1Prod_q   <= '0;
        end else begin
            state_q    <= state_d;
            scan_q     <= scan_d;
            outValid_q <= outValid_d;
            outRow_q   <= outRow_d;
            outData_q  <= outData_d;
            outLast_q  <= outLast_d;
            s1Valid_q  <= wHit;
            if (wHit) begin
                s1Row_q  <= w_row_i;
                s1Prod_q <= prod;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) x_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            for (int i = 0; i < DIM; i++) x_q[i] <= '0;
        end else if (vecHit) begin
            x_q[vec_idx_i] <= vec_data_i;
        end
    end

    // A single read-modify-write stage, so consecutive triplets to one row see each other's sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) acc_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            for (int i = 0; i < DIM; i++) acc_q[i] <= '0;
        end else if (s1Valid_q) begin
            acc_q[s1Row_q] <= acc_q[s1Row_q] + addend;
        end
    end

    assign out_valid_o = outValid_q;
    assign out_row_o   = outRow_q;
    assign out_data_o  = outData_q;
    assign out_last_o  = outLast_q;

endmodule

// File: tb/tb_spmv_stream.sv
// Drives two spmv_stream builds (32/unsigned/skip and 20/signed/no-skip) from shared inputs;
// a per-build arithmetic model fills expected-beat queues that independent monitors drain.
module tb_spmv_stream;

    typedef struct packed {
        logic [4:0]  row;
        logic [20:0] data;
        logic        last;
    } beat_t;

    logic clk;
    logic rst_n;

    logic       vecValid, wValid, wLast;
    logic [4:0] vecIdx, wRow, wCol;
    logic [7:0] vecData, wData;

    logic        inReadyA, outValidA, readyA, outLastA;
    logic [4:0]  outRowA;
    logic [20:0] outDataA;
    logic        inReadyB, outValidB, readyB, outLastB;
    logic [4:0]  outRowB;
    logic [20:0] outDataB;

    int checks   = 0;
    int failures = 0;
    int readyMode = 0;

    beat_t expA[$];
    beat_t expB[$];

    int     dimC[2]  = '{32, 20};
    bit     sgnC[2]  = '{1'b0, 1'b1};
    bit     skipC[2] = '{1'b1, 1'b0};
    longint xm[2][32];
    longint sm[2][32];

    spmv_stream #(.DIM(32), .DW(8), .SIGNED(0), .SKIP_ZERO(1)) dutA (
        .clk(clk), .rst_n(rst_n), .in_ready_o(inReadyA),
        .vec_valid_i(vecValid), .vec_idx_i(vecIdx), .vec_data_i(vecData),
        .w_valid_i(wValid), .w_row_i(wRow), .w_col_i(wCol), .w_data_i(wData), .w_last_i(wLast),
        .out_valid_o(outValidA), .out_ready_i(readyA), .out_row_o(outRowA),
        .out_data_o(outDataA), .out_last_o(outLastA)
    );

    spmv_stream #(.DIM(20), .DW(8), .SIGNED(1), .SKIP_ZERO(0)) dutB (
        .clk(clk), .rst_n(rst_n), .in_ready_o(inReadyB),
        .vec_valid_i(vecValid), .vec_idx_i(vecIdx), .vec_data_i(vecData),
        .w_valid_i(wValid), .w_row_i(wRow), .w_col_i(wCol), .w_data_i(wData), .w_last_i(wLast),
        .out_valid_o(outValidB), .out_ready_i(readyB), .out_row_o(outRowB),
        .out_data_o(outDataB), .out_last_o(outLastB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    function automatic longint ext8(input logic [7:0] v, input bit s);
        if (s) return longint'($signed(v));
        return longint'(v);
    endfunction

    function automatic void clearModel();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 32; i++) begin
                xm[c][i] = 0;
                sm[c][i] = 0;
            end
    endfunction

    // One input cycle; the model applies the weight before the same-cycle x write.
    task automatic applyStimulus(input bit vv, input int vi, input int vd,
                                 input bit wv, input int wr, input int wc, input int wd, input bit wl);
        logic [20:0] sum21;
        beat_t       b;
        @(posedge clk);
        #1;
        vecValid = vv; vecIdx = 5'(vi); vecData = 8'(vd);
        wValid = wv; wRow = 5'(wr); wCol = 5'(wc); wData = 8'(wd); wLast = wl;
        for (int c = 0; c < 2; c++) begin
            if (wv && wr < dimC[c] && wc < dimC[c])
                sm[c][wr] += ext8(8'(wd), sgnC[c]) * xm[c][wc];
            if (vv && vi < dimC[c])
                xm[c][vi] = ext8(8'(vd), sgnC[c]);
            if (wv && wl) begin
                for (int r = 0; r < dimC[c]; r++) begin
                    sum21 = 21'(sm[c][r]);
                    if (!skipC[c] || sum21 != 0 || r == dimC[c] - 1) begin
                        b = '{row: 5'(r), data: sum21, last: (r == dimC[c] - 1)};
                        if (c == 0) expA.push_back(b);
                        else        expB.push_back(b);
                    end
                end
            end
        end
        if (wv && wl) clearModel();
    endtask

    task automatic waitBatch(input string tag);
        bit done;
        done = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800 && !done; i++) begin
            @(posedge clk);
            #1;
            if (expA.size() == 0 && expB.size() == 0 && inReadyA && inReadyB) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL %s completion: pending A=%0d B=%0d inReady=%b%b, required 0 0 11",
                     tag, expA.size(), expB.size(), inReadyA, inReadyB);
            expA.delete();
            expB.delete();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " A in_ready"}, 32'(inReadyA), 32'd1);
        checkOutput({tag, " A out_valid"}, 32'(outValidA), 32'd0);
        checkOutput({tag, " A out_row"}, 32'(outRowA), 32'd0);
        checkOutput({tag, " A out_data"}, 32'(outDataA), 32'd0);
        checkOutput({tag, " A out_last"}, 32'(outLastA), 32'd0);
        checkOutput({tag, " B in_ready"}, 32'(inReadyB), 32'd1);
        checkOutput({tag, " B out_valid"}, 32'(outValidB), 32'd0);
        checkOutput({tag, " B out_data"}, 32'(outDataB), 32'd0);
    endtask

    task automatic sparseBatch();
        applyStimulus(1, 3, 5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 3, 7, 0);
        applyStimulus(0, 0, 0, 1, 10, 3, 2, 1);
    endtask

    int phase = 0;
    initial begin
        readyA = 1'b1;
        readyB = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % 3;
            case (readyMode)
                1: begin readyA = (phase == 0); readyB = (phase == 0); end
                2: begin readyA = 1'($urandom_range(0, 1)); readyB = 1'($urandom_range(0, 1)); end
                default: begin readyA = 1'b1; readyB = 1'b1; end
            endcase
        end
    end

    bit          stallA = 1'b0, stallB = 1'b0;
    logic [26:0] heldA, heldB;
    beat_t       eA, eB;

    always @(negedge clk) begin
        if (!rst_n) stallA = 1'b0;
        else begin
            if (stallA) begin
                checkOutput("A stall valid", 32'(outValidA), 32'd1);
                checkOutput("A stall hold", 32'({outRowA, outDataA, outLastA}), 32'(heldA));
            end
            if (outValidA && readyA) begin
                if (expA.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL A unexpected beat: row=%0d data=%0d, required none", outRowA, outDataA);
                end else begin
                    eA = expA.pop_front();
                    checkOutput($sformatf("A beat row %0d", eA.row), 32'({outRowA, outDataA, outLastA}), 32'(eA));
                end
            end
            stallA = outValidA && !readyA;
            heldA  = {outRowA, outDataA, outLastA};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) stallB = 1'b0;
        else begin
            if (stallB) begin
                checkOutput("B stall valid", 32'(outValidB), 32'd1);
                checkOutput("B stall hold", 32'({outRowB, outDataB, outLastB}), 32'(heldB));
            end
            if (outValidB && readyB) begin
                if (expB.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL B unexpected beat: row=%0d data=%0d, required none", outRowB, outDataB);
                end else begin
                    eB = expB.pop_front();
                    checkOutput($sformatf("B beat row %0d", eB.row), 32'({outRowB, outDataB, outLastB}), 32'(eB));
                end
            end
            stallB = outValidB && !readyB;
            heldB  = {outRowB, outDataB, outLastB};
        end
    end

    initial begin
        bit seen;
        int n;
        clearModel();
        rst_n = 1'b0;
        vecValid = 0; vecIdx = 0; vecData = 0;
        wValid = 0; wRow = 0; wCol = 0; wData = 0; wLast = 0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;

        $display("[TB] identity");
        for (int i = 0; i < 32; i++) applyStimulus(1, i, i + 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 1, i, i, 1, i == 31);
        waitBatch("identity");

        $display("[TB] sparse skip");
        sparseBatch();
        waitBatch("sparse");

        $display("[TB] same-row hazard");
        applyStimulus(1, 0, 255, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 255, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 4, 0, 255, 0);
        applyStimulus(0, 0, 0, 1, 4, 1, 255, 0);
        applyStimulus(0, 0, 0, 1, 4, 0, 255, 1);
        waitBatch("hazard");

        $display("[TB] backpressure");
        readyMode = 1;
        sparseBatch();
        waitBatch("backpressure");
        readyMode = 0;

        $display("[TB] full-width sums");
        for (int j = 0; j < 32; j++) applyStimulus(1, j, 128, 0, 0, 0, 0, 0);
        for (int j = 0; j < 32; j++) applyStimulus(0, 0, 0, 1, 0, j, 128, j == 31);
        waitBatch("width-128");
        for (int j = 0; j < 32; j++) applyStimulus(1, j, 255, 0, 0, 0, 0, 0);
        for (int j = 0; j < 32; j++) applyStimulus(0, 0, 0, 1, 0, j, 255, j == 31);
        waitBatch("width-255");

        $display("[TB] same-cycle write and out-of-range indices");
        applyStimulus(1, 2, 4, 0, 0, 0, 0, 0);
        applyStimulus(1, 2, 9, 1, 1, 2, 3, 1);
        waitBatch("same-cycle");
        applyStimulus(1, 3, 6, 0, 0, 0, 0, 0);
        applyStimulus(1, 25, 9, 1, 22, 3, 5, 0);
        applyStimulus(0, 0, 0, 1, 2, 25, 4, 0);
        applyStimulus(0, 0, 0, 1, 5, 3, 2, 1);
        waitBatch("out-of-range");
        applyStimulus(0, 0, 0, 1, 25, 25, 9, 1);
        waitBatch("empty");

        $display("[TB] random batches");
        readyMode = 2;
        for (int b = 0; b < 8; b++) begin
            n = $urandom_range(1, 40);
            for (int k = 0; k < n; k++)
                applyStimulus($urandom_range(0, 1), $urandom_range(0, 31),
                              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
                              (k == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                              $urandom_range(0, 31), $urandom_range(0, 31),
                              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
                              k == n - 1);
            waitBatch($sformatf("random %0d", b));
        end

        $display("[TB] reset during output");
        for (int i = 0; i < 32; i++) applyStimulus(1, i, i + 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 1, i, 31 - i, 2, i == 31);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (outValidA) seen = 1'b1;
        end
        checkOutput("reached output phase", 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid-output reset");
        expA.delete();
        expB.delete();
        clearModel();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        readyMode = 0;
        sparseBatch();
        waitBatch("post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
